// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encodings
// and the default operand width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : serial_add_pkg

// File: rtl/full_adder_bit.sv
// One-bit adder slice driven by serial_add_ctrl: two half adders whose carries
// are ORed into the slice carry-out.
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule : half_adder

module full_adder_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (
    .i_a (i_a),
    .i_b (i_b),
    .o_s (w_s0),
    .o_c (w_c0)
  );

  half_adder u_ha1 (
    .i_a (w_s0),
    .i_b (i_cin),
    .o_s (o_s),
    .o_c (w_c1)
  );

  // The two half-adder carries can never both be 1, so OR equals the full carry.
  assign o_cout = w_c0 | w_c1;

endmodule : full_adder_bit

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds one full_adder_bit LSB first for WIDTH
// cycles. Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;

  logic w_sub;
  logic w_accept;
  logic w_last;
  logic w_sum_bit;
  logic w_carry_out;

`ifdef SERIAL_ADD_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_last   = (r_state == ST_RUN) && (r_cnt == CNT_LAST);

  full_adder_bit u_slice (
    .i_a    (r_a_sr[0]),
    .i_b    (r_b_sr[0]),
    .i_cin  (r_carry),
    .o_s    (w_sum_bit),
    .o_cout (w_carry_out)
  );

  // NOTE: state is updated with <= so every flop samples pre-edge values;
  // blocking assignments here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the default assignment first means every path drives w_state_nxt,
  // so no latch is inferred for cases that leave it untouched.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (start)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      if (w_accept) begin
        // Subtract is a + ~b + 1: invert b on load and seed the carry with 1.
        r_a_sr  <= a;
        r_b_sr  <= w_sub ? ~b : b;
        r_carry <= w_sub;
        r_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
        r_a_sr  <= r_a_sr >> 1;
        r_b_sr  <= r_b_sr >> 1;
        r_acc   <= {w_sum_bit, r_acc[WIDTH-1:1]};
        r_carry <= w_carry_out;
        r_cnt   <= r_cnt + CNT_W'(1);
      end

      // Publish only on the completing edge so partial sums never escape.
      if (w_last) begin
        r_sum  <= {w_sum_bit, r_acc[WIDTH-1:1]};
        r_cout <= w_carry_out;
      end
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8): directed requests push expected
// results; a negedge monitor pops and compares on every done pulse.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  localparam int MODE_ADD    = 0;
  localparam int MODE_REPULS = 1;
  localparam int MODE_ABORT  = 2;
  localparam int MODE_SUB    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks       = 0;
  int failures     = 0;
  int done_seen    = 0;
  int ops_expected = 0;

  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] mon_exp;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sum", 32'(sum), 32'(mon_exp[WIDTH-1:0]));
        check("cout", 32'(cout), 32'(mon_exp[WIDTH]));
      end
    end
  end

  // Issues one request; E0 is the posedge that samples start=1.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic [WIDTH-1:0] es, input logic ec, input int mode);
    int n;
    @(posedge clk); #1;
    a     = av;
    b     = bv;
    start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    sub   = (mode == MODE_SUB);
`endif
    @(posedge clk);
    if (mode != MODE_ABORT) begin
      exp_q.push_back({ec, es});
      ops_expected++;
    end
    #1;
    start = 1'b0;
    a     = ~av;
    b     = ~bv;
`ifdef SERIAL_ADD_SUB_EN
    sub   = ~sub;
`endif
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (mode == MODE_REPULS && n == 3) begin
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h01;
      end
      if (mode == MODE_REPULS && n == 4) start = 1'b0;
      if (mode == MODE_ABORT && n == 4) rst = 1'b1;
      if (mode == MODE_ABORT && n == 5) break;
      if (done === 1'b1) break;
      check("busy_during_run", 32'(busy), 32'd1);
    end

    if (mode == MODE_ABORT) begin
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_sum", 32'(sum), 32'd0);
      check("abort_cout", 32'(cout), 32'd0);
      #1 rst = 1'b0;
    end else begin
      // done is seen at the (WIDTH+1)-th negedge after E0, i.e. after E0+WIDTH.
      check("latency", 32'(n), 32'(WIDTH + 1));
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("busy_fall", 32'(busy), 32'd0);
      if (mode == MODE_REPULS) repeat (WIDTH + 3) @(negedge clk);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
`ifdef SERIAL_ADD_SUB_EN
    sub   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);

    run_op(8'h00, 8'h00, 8'h00, 1'b0, MODE_ADD);
    run_op(8'h5A, 8'h3C, 8'h96, 1'b0, MODE_ADD);
    run_op(8'hFF, 8'h01, 8'h00, 1'b1, MODE_ADD);
    run_op(8'hFF, 8'hFF, 8'hFE, 1'b1, MODE_ADD);
    run_op(8'h12, 8'h34, 8'h46, 1'b0, MODE_REPULS);
    run_op(8'h77, 8'h11, 8'h88, 1'b0, MODE_ABORT);
    run_op(8'h80, 8'h80, 8'h00, 1'b1, MODE_ADD);
    run_op(8'hA5, 8'h0F, 8'hB4, 1'b0, MODE_ADD);
`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h10, 8'h01, 8'h0F, 1'b1, MODE_SUB);
    run_op(8'h01, 8'h02, 8'hFF, 1'b0, MODE_SUB);
`endif

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("done_pulses", 32'(done_seen), 32'(ops_expected));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_add_ctrl

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller. It accepts one WIDTH-bit add request through a start/done handshake. It then drives a single one-bit adder slice for WIDTH consecutive cycles, LSB first, and presents the full sum and carry-out. The block sequences the team's half-adder datapath so that a one-bit resource can perform a multi-bit add. It sits between a requesting controller or testbench stimulus and the adder slice.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock, sole clock
- rst  input  1  reset, synchronous and active-high
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- sub  input  1  subtract select; captured with operands; present only with SERIAL_ADD_SUB_EN
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  last completed result, held until next completion
- cout  output  1  carry-out of last completed result

## Operation
- States: IDLE, RUN, DONE. Binary encoding, 2 bits.
- IDLE → RUN on start=1. Latch a and b into right-shift registers. Clear the bit counter. Load the carry register with 0 (or sub, see Configuration).
- RUN, each edge:
  - Slice inputs: a_sr[0], b_sr[0], carry.
  - Slice sum bit shifts into the MSB of the internal accumulator. a_sr and b_sr shift right. carry ← slice carry. Counter increments.
- RUN → DONE on the edge where counter = WIDTH-1, i.e. the WIDTH-th RUN edge. The same edge copies the completed accumulator to sum and the final carry to cout.
- DONE → IDLE unconditionally on the next edge. done = (state == DONE).
- start is ignored in RUN and DONE. No queueing.
- The operands are captured at the accepting edge. Later changes on a or b do not affect the result.
- Arithmetic: result = (a + b + cin) mod 2^WIDTH, where cin = 0 for add. cout is the carry out of bit WIDTH-1.
- sum and cout change only on the completing edge or on reset. They never expose partial results.
- Counter width is $clog2(WIDTH). It must not wrap before the compare.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. Counter, shift registers and carry register are all 0.
- rst takes priority over all other activity. Reset during RUN or DONE aborts the operation, discards the partial result and clears sum and cout to 0.
- Latency: let E0 be the edge that samples start=1.
  - busy rises after E0.
  - sum, cout and done become valid after edge E0+WIDTH.
  - done stays high for exactly one cycle. busy falls after E0+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accept is the edge after DONE, i.e. start held high continuously restarts at E0+WIDTH+2.
- A start pulse coinciding with the DONE cycle is lost.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - The sub port exists.
  - When sub=1 at accept, b is inverted bitwise into b_sr and carry is loaded with 1, so result = a − b mod 2^WIDTH.
  - cout=1 means no borrow.
- SERIAL_ADD_SUB_EN undefined:
  - The sub port is absent.
  - The carry register is always loaded with 0.
  - The block performs add only.

## Structure
- Shared package/include serial_add_pkg:
  - State encodings ST_IDLE, ST_RUN, ST_DONE.
  - Default WIDTH constant.
- One sub-module, full_adder_bit: the one-bit slice, built from two half_adder instances plus an OR on the carries. It is instantiated once by serial_add_ctrl.
- All sequencing, shift registers and the counter live in serial_add_ctrl.

## Test plan (WIDTH=8)
- After reset, with no start: busy=0, done=0, sum=0x00, cout=0. A 0x00+0x00 request then gives a done pulse with sum=0x00 and cout=0.
- a=0x5A, b=0x3C, start one cycle → done pulse after exactly 8 edges with sum=0x96 and cout=0. busy is high for 9 cycles.
- a=0xFF, b=0x01 → sum=0x00, cout=1. Then a=0xFF, b=0xFF → sum=0xFE, cout=1.
- start re-pulsed with a=0x01, b=0x01 during RUN → ignored. The first result is unchanged and only one done pulse occurs. Operand changes after accept have no effect.
- rst asserted at the 4th RUN edge → next cycle state=IDLE, busy=0, sum=0, cout=0, no done pulse. A fresh request afterwards completes normally.
- With SERIAL_ADD_SUB_EN defined:
  - 0x10−0x01 → sum=0x0F, cout=1.
  - 0x01−0x02 → sum=0xFF, cout=0.
